// File: rtl/fb_pkg.sv
// Shared types and constants for the double-buffered framebuffer writer.
package fb_pkg;

  localparam int unsigned H_RES     = 320;
  localparam int unsigned V_RES     = 180;
  localparam int unsigned FB_PIXELS = H_RES * V_RES;
  localparam logic [15:0] FB_LAST   = 16'(FB_PIXELS - 1);

  typedef enum logic [1:0] {
    DRAW,
    DRAIN,
    SWAP_WAIT,
    CLEAR
  } fb_state_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] color;
  } fb_pixel_t;

  function automatic logic in_range(input logic [15:0] addr);
    return addr <= FB_LAST;
  endfunction

endpackage

// File: rtl/fb_pixel_fifo.sv
// Synchronous pixel FIFO; a push while full is accepted when a pop happens in the same cycle.
module fb_pixel_fifo
  import fb_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       push_in,
  input  fb_pixel_t                  data_in,
  input  logic                       pop_in,
  output fb_pixel_t                  data_out,
  output logic                       full_out,
  output logic                       empty_out,
  output logic [$clog2(DEPTH):0]     count_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fb_pixel_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_out  = (count_q == CW'(DEPTH));
  assign empty_out = (count_q == '0);
  assign count_out = count_q;
  assign data_out  = mem[rd_ptr_q];

  assign do_pop  = pop_in && !empty_out;
  assign do_push = push_in && (!full_out || do_pop);

  // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  // NOTE: flops use non-blocking assignments so all state updates see pre-edge values.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk_in) begin
    if (do_push) mem[wr_ptr_q] <= data_in;
  end

endmodule

// File: rtl/framebuffer_writer.sv
// Commits pixel writes to a double-buffered framebuffer and swaps banks on vsync after frame_done.
// Optional back-bank clear sweep after each swap is enabled by defining FB_CLEAR_EN.
module framebuffer_writer
  import fb_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [15:0] CLEAR_COLOR = 16'h0000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [15:0] addr_in,
  input  logic [15:0] color_in,
  input  logic        data_valid_in,
  input  logic        frame_done_in,
  input  logic        vsync_in,
  output logic        ready_out,
  output logic [16:0] fb_addr_out,
  output logic [15:0] fb_data_out,
  output logic        fb_we_out,
  output logic        front_bank_out,
  output logic        overflow_out,
  output logic [15:0] dropped_count_out
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fb_state_t   state_q, state_d;
  logic        front_bank_q, front_bank_d;
`ifdef FB_CLEAR_EN
  logic [15:0] clr_cnt_q, clr_cnt_d;
`endif
  logic        fb_we_q, fb_we_d;
  logic [16:0] fb_addr_q, fb_addr_d;
  logic [15:0] fb_data_q, fb_data_d;
  logic        ready_q, ready_d;
  logic        overflow_q, overflow_d;
  logic [15:0] dropped_q, dropped_d;

  logic          push, pop, accepting, pix_ok;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count, count_next;
  fb_pixel_t     fifo_head, pix_in;

  assign pix_in = '{addr: addr_in, color: color_in};

  fb_pixel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push_in   (push),
    .data_in   (pix_in),
    .pop_in    (pop),
    .data_out  (fifo_head),
    .full_out  (fifo_full),
    .empty_out (fifo_empty),
    .count_out (fifo_count)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= DRAW;
      front_bank_q <= 1'b0;
`ifdef FB_CLEAR_EN
      clr_cnt_q    <= '0;
`endif
      fb_we_q      <= 1'b0;
      fb_addr_q    <= '0;
      fb_data_q    <= '0;
      ready_q      <= 1'b0;
      overflow_q   <= 1'b0;
      dropped_q    <= '0;
    end else begin
      state_q      <= state_d;
      front_bank_q <= front_bank_d;
`ifdef FB_CLEAR_EN
      clr_cnt_q    <= clr_cnt_d;
`endif
      fb_we_q      <= fb_we_d;
      fb_addr_q    <= fb_addr_d;
      fb_data_q    <= fb_data_d;
      ready_q      <= ready_d;
      overflow_q   <= overflow_d;
      dropped_q    <= dropped_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    front_bank_d = front_bank_q;
`ifdef FB_CLEAR_EN
    clr_cnt_d    = clr_cnt_q;
`endif
    case (state_q)
      DRAW:      if (frame_done_in) state_d = DRAIN;
      DRAIN:     if (fifo_empty)    state_d = SWAP_WAIT;
      SWAP_WAIT: if (vsync_in) begin
        front_bank_d = ~front_bank_q;
`ifdef FB_CLEAR_EN
        state_d      = CLEAR;
        clr_cnt_d    = '0;
`else
        state_d      = DRAW;
`endif
      end
`ifdef FB_CLEAR_EN
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + 16'd1;
        if (clr_cnt_q == FB_LAST) state_d = DRAW;
      end
`endif
      default: state_d = DRAW;
    endcase
  end

  always_comb begin
    accepting = (state_q != DRAIN);
    pix_ok    = data_valid_in && accepting && in_range(addr_in);
    pop       = ((state_q == DRAW) || (state_q == DRAIN)) && !fifo_empty;
    push      = pix_ok && (!fifo_full || pop);

    overflow_d = overflow_q | (pix_ok && fifo_full && !pop);
    dropped_d  = dropped_q;
    if (data_valid_in && !push && (dropped_q != 16'hFFFF)) dropped_d = dropped_q + 16'd1;

    // ready reflects the state and occupancy the next cycle will actually have
    count_next = fifo_count + CW'(push) - CW'(pop);
    ready_d    = (state_d != DRAIN) && (count_next != CW'(FIFO_DEPTH));

    fb_we_d   = pop;
    fb_addr_d = pop ? {~front_bank_q, fifo_head.addr} : '0;
    fb_data_d = pop ? fifo_head.color : CLEAR_COLOR;
`ifdef FB_CLEAR_EN
    if (state_q == CLEAR) begin
      fb_we_d   = 1'b1;
      fb_addr_d = {~front_bank_q, clr_cnt_q};
      fb_data_d = CLEAR_COLOR;
    end
`endif
  end

  assign ready_out         = ready_q;
  assign fb_we_out         = fb_we_q;
  assign fb_addr_out       = fb_addr_q;
  assign fb_data_out       = fb_data_q;
  assign front_bank_out    = front_bank_q;
  assign overflow_out      = overflow_q;
  assign dropped_count_out = dropped_q;

endmodule

// File: tb/tb_framebuffer_writer.sv
// Self-checking bench for framebuffer_writer: randomized pixels against a queue-based write model.
module tb_framebuffer_writer;

  localparam int          FB_PIX = 320 * 180;
  localparam int          DEPTH  = 16;
  localparam logic [15:0] CLR    = 16'h0000;
`ifdef FB_CLEAR_EN
  localparam int N_CLEAR = FB_PIX;
`else
  localparam int N_CLEAR = 0;
`endif

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [15:0] addr_in = '0;
  logic [15:0] color_in = '0;
  logic        data_valid_in = 1'b0;
  logic        frame_done_in = 1'b0;
  logic        vsync_in = 1'b0;
  logic        ready_out;
  logic [16:0] fb_addr_out;
  logic [15:0] fb_data_out;
  logic        fb_we_out;
  logic        front_bank_out;
  logic        overflow_out;
  logic [15:0] dropped_count_out;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_dropped = 0;
  logic exp_front = 1'b0;
  logic [32:0] got[$];

  framebuffer_writer dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .addr_in           (addr_in),
    .color_in          (color_in),
    .data_valid_in     (data_valid_in),
    .frame_done_in     (frame_done_in),
    .vsync_in          (vsync_in),
    .ready_out         (ready_out),
    .fb_addr_out       (fb_addr_out),
    .fb_data_out       (fb_data_out),
    .fb_we_out         (fb_we_out),
    .front_bank_out    (front_bank_out),
    .overflow_out      (overflow_out),
    .dropped_count_out (dropped_count_out)
  );

  always #5 clk_in = ~clk_in;

  // Record every committed write just after the edge that produced it.
  always @(posedge clk_in) begin
    #1;
    if (fb_we_out === 1'b1) got.push_back({fb_addr_out, fb_data_out});
  end

  task automatic idle(input int n);
    data_valid_in = 1'b0;
    frame_done_in = 1'b0;
    vsync_in      = 1'b0;
    repeat (n) @(negedge clk_in);
  endtask

  function automatic logic [15:0] rand_addr_in();
    return 16'($urandom_range(0, FB_PIX - 1));
  endfunction

  task automatic test_reset();
    rst_in = 1'b1;
    idle(2);
    n_cmp++; if (fb_we_out !== 1'b0) begin n_bad++; $display("FAIL reset_we: got %b expected 0", fb_we_out); end
    n_cmp++; if (fb_addr_out !== 17'h0) begin n_bad++; $display("FAIL reset_addr: got %h expected 0", fb_addr_out); end
    n_cmp++; if (front_bank_out !== 1'b0) begin n_bad++; $display("FAIL reset_front: got %b expected 0", front_bank_out); end
    n_cmp++; if (overflow_out !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %b expected 0", overflow_out); end
    n_cmp++; if (dropped_count_out !== 16'h0) begin n_bad++; $display("FAIL reset_dropped: got %h expected 0", dropped_count_out); end
    n_cmp++; if (ready_out !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b expected 0", ready_out); end
    rst_in = 1'b0;
    @(negedge clk_in);
    n_cmp++; if (ready_out !== 1'b1) begin n_bad++; $display("FAIL post_reset_ready: got %b expected 1", ready_out); end
    exp_dropped = 0;
    exp_front   = 1'b0;
  endtask

  task automatic test_latency();
    got.delete();
    addr_in = 16'd5; color_in = 16'h001F; data_valid_in = 1'b1;
    @(negedge clk_in);
    data_valid_in = 1'b0;
    n_cmp++; if (fb_we_out !== 1'b0) begin n_bad++; $display("FAIL lat_n1_we: got %b expected 0", fb_we_out); end
    @(negedge clk_in);
    n_cmp++; if (fb_we_out !== 1'b1) begin n_bad++; $display("FAIL lat_n2_we: got %b expected 1", fb_we_out); end
    n_cmp++; if (fb_addr_out !== 17'h1_0005) begin n_bad++; $display("FAIL lat_n2_addr: got %h expected 10005", fb_addr_out); end
    n_cmp++; if (fb_data_out !== 16'h001F) begin n_bad++; $display("FAIL lat_n2_data: got %h expected 001f", fb_data_out); end
    @(negedge clk_in);
    n_cmp++; if (fb_we_out !== 1'b0) begin n_bad++; $display("FAIL lat_n3_we: got %b expected 0", fb_we_out); end
    got.delete();
  endtask

  task automatic test_out_of_range();
    logic [15:0] c;
    logic [32:0] e;
    c = 16'($urandom);
    got.delete();
    data_valid_in = 1'b1; addr_in = 16'(FB_PIX - 1); color_in = c;
    @(negedge clk_in);
    addr_in = 16'(FB_PIX); color_in = ~c;
    exp_dropped++;
    @(negedge clk_in);
    idle(4);
    e = {~exp_front, 16'(FB_PIX - 1), c};
    n_cmp++; if (got.size() !== 1) begin n_bad++; $display("FAIL oor_write_count: got %0d expected 1", got.size()); end
    if (got.size() >= 1) begin
      n_cmp++; if (got[0] !== e) begin n_bad++; $display("FAIL oor_last_pixel: got %h expected %h", got[0], e); end
    end
    n_cmp++; if (dropped_count_out !== 16'(exp_dropped)) begin n_bad++; $display("FAIL oor_dropped: got %0d expected %0d", dropped_count_out, exp_dropped); end
    n_cmp++; if (overflow_out !== 1'b0) begin n_bad++; $display("FAIL oor_overflow: got %b expected 0", overflow_out); end
  endtask

  task automatic test_random_draw();
    logic [32:0] exp_q[$];
    logic        v, oor;
    logic [15:0] a, c;
    int          n;
    got.delete();
    for (int i = 0; i < 300; i++) begin
      v   = ($urandom_range(0, 3) != 0);
      oor = ($urandom_range(0, 4) == 0);
      a   = oor ? 16'($urandom_range(FB_PIX, 65535)) : rand_addr_in();
      c   = 16'($urandom);
      n_cmp++; if (ready_out !== 1'b1) begin n_bad++; $display("FAIL rand_ready[%0d]: got %b expected 1", i, ready_out); end
      data_valid_in = v; addr_in = a; color_in = c;
      if (v) begin
        if (oor) exp_dropped++;
        else exp_q.push_back({~exp_front, a, c});
      end
      @(negedge clk_in);
    end
    idle(6);
    n_cmp++; if (got.size() !== exp_q.size()) begin n_bad++; $display("FAIL rand_write_count: got %0d expected %0d", got.size(), exp_q.size()); end
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      n_cmp++; if (got[i] !== exp_q[i]) begin n_bad++; $display("FAIL rand_write[%0d]: got %h expected %h", i, got[i], exp_q[i]); end
    end
    n_cmp++; if (dropped_count_out !== 16'(exp_dropped)) begin n_bad++; $display("FAIL rand_dropped: got %0d expected %0d", dropped_count_out, exp_dropped); end
    n_cmp++; if (overflow_out !== 1'b0) begin n_bad++; $display("FAIL rand_overflow: got %b expected 0", overflow_out); end
  endtask

  task automatic test_swap();
    logic [32:0] p[3];
    logic [32:0] kept[$];
    logic [32:0] e;
    logic [15:0] a, c;
    int          k, total, bad;
    got.delete();
    for (int i = 0; i < 3; i++) begin
      a = rand_addr_in(); c = 16'($urandom);
      p[i] = {~exp_front, a, c};
      data_valid_in = 1'b1; addr_in = a; color_in = c; frame_done_in = (i == 2);
      @(negedge clk_in);
    end
    frame_done_in = 1'b0;
    n_cmp++; if (ready_out !== 1'b0) begin n_bad++; $display("FAIL drain_ready: got %b expected 0", ready_out); end
    // a pixel and a vsync while draining are both discarded
    addr_in = rand_addr_in(); vsync_in = 1'b1;
    exp_dropped++;
    @(negedge clk_in);
    idle(0);
    k = 0;
    while (ready_out !== 1'b1 && k < 10) begin @(negedge clk_in); k++; end
    n_cmp++; if (ready_out !== 1'b1) begin n_bad++; $display("FAIL swap_wait_reached: got ready %b expected 1", ready_out); end
    n_cmp++; if (front_bank_out !== exp_front) begin n_bad++; $display("FAIL vsync_in_drain_front: got %b expected %b", front_bank_out, exp_front); end
    n_cmp++; if (got.size() !== 3) begin n_bad++; $display("FAIL frame_write_count: got %0d expected 3", got.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < got.size()) begin
        n_cmp++; if (got[i] !== p[i]) begin n_bad++; $display("FAIL frame_write[%0d]: got %h expected %h", i, got[i], p[i]); end
      end
    end

    // SWAP_WAIT holds pixels without writing; the FIFO fills and the excess is dropped
    for (int i = 0; i < 20; i++) begin
      a = rand_addr_in(); c = 16'($urandom);
      if (i < DEPTH) kept.push_back({exp_front, a, c});
      else exp_dropped++;
      data_valid_in = 1'b1; addr_in = a; color_in = c;
      @(negedge clk_in);
    end
    data_valid_in = 1'b0;
    n_cmp++; if (ready_out !== 1'b0) begin n_bad++; $display("FAIL full_ready: got %b expected 0", ready_out); end
    n_cmp++; if (overflow_out !== 1'b1) begin n_bad++; $display("FAIL full_overflow: got %b expected 1", overflow_out); end
    n_cmp++; if (dropped_count_out !== 16'(exp_dropped)) begin n_bad++; $display("FAIL full_dropped: got %0d expected %0d", dropped_count_out, exp_dropped); end
    n_cmp++; if (got.size() !== 3) begin n_bad++; $display("FAIL swap_wait_no_write: got %0d writes expected 3", got.size()); end

    vsync_in = 1'b1;
    @(negedge clk_in);
    vsync_in  = 1'b0;
    exp_front = ~exp_front;
    n_cmp++; if (front_bank_out !== exp_front) begin n_bad++; $display("FAIL swap_front: got %b expected %b", front_bank_out, exp_front); end
    @(negedge clk_in);
`ifdef FB_CLEAR_EN
    e = {~exp_front, 16'h0000, CLR};
`else
    e = kept[0];
`endif
    n_cmp++; if (fb_we_out !== 1'b1 || {fb_addr_out, fb_data_out} !== e) begin
      n_bad++; $display("FAIL first_write_after_swap: got we=%b %h expected we=1 %h", fb_we_out, {fb_addr_out, fb_data_out}, e);
    end
    total = 3 + N_CLEAR + DEPTH;
    k = 0;
    while (got.size() < total && k < N_CLEAR + 200) begin @(negedge clk_in); k++; end
    idle(4);
    n_cmp++; if (got.size() !== total) begin n_bad++; $display("FAIL swap_write_count: got %0d expected %0d", got.size(), total); end
`ifdef FB_CLEAR_EN
    bad = 0;
    for (int i = 0; i < N_CLEAR; i++) begin
      if (3 + i >= got.size() || got[3 + i] !== {~exp_front, 16'(i), CLR}) bad++;
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL clear_sweep: got %0d bad clear writes expected 0", bad); end
`else
    bad = 0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      if (3 + N_CLEAR + i < got.size()) begin
        n_cmp++; if (got[3 + N_CLEAR + i] !== kept[i]) begin
          n_bad++; $display("FAIL kept_write[%0d]: got %h expected %h", i, got[3 + N_CLEAR + i], kept[i]);
        end
      end
    end
    n_cmp++; if (ready_out !== 1'b1) begin n_bad++; $display("FAIL post_swap_ready: got %b expected 1", ready_out); end
  endtask

  task automatic test_reset_mid_op();
    got.delete();
    frame_done_in = 1'b1;
    @(negedge clk_in);
    idle(4);
    for (int i = 0; i < 5; i++) begin
      data_valid_in = 1'b1; addr_in = rand_addr_in(); color_in = 16'($urandom);
      @(negedge clk_in);
    end
    data_valid_in = 1'b0;
`ifdef FB_CLEAR_EN
    vsync_in = 1'b1;
    @(negedge clk_in);
    idle(100);
`endif
    rst_in = 1'b1;
    @(negedge clk_in);
    n_cmp++; if (fb_we_out !== 1'b0) begin n_bad++; $display("FAIL midrst_we: got %b expected 0", fb_we_out); end
    n_cmp++; if (front_bank_out !== 1'b0) begin n_bad++; $display("FAIL midrst_front: got %b expected 0", front_bank_out); end
    n_cmp++; if (overflow_out !== 1'b0) begin n_bad++; $display("FAIL midrst_overflow: got %b expected 0", overflow_out); end
    n_cmp++; if (dropped_count_out !== 16'h0) begin n_bad++; $display("FAIL midrst_dropped: got %0d expected 0", dropped_count_out); end
    rst_in      = 1'b0;
    exp_dropped = 0;
    exp_front   = 1'b0;
    got.delete();
    idle(10);
    n_cmp++; if (got.size() !== 0) begin n_bad++; $display("FAIL midrst_no_resume: got %0d writes expected 0", got.size()); end
    n_cmp++; if (ready_out !== 1'b1) begin n_bad++; $display("FAIL midrst_ready: got %b expected 1", ready_out); end
  endtask

`ifndef FB_CLEAR_EN
  task automatic test_saturation();
    int n;
    n = 65540;
    data_valid_in = 1'b1; addr_in = 16'hFFFF; color_in = 16'h1234;
    repeat (n) @(negedge clk_in);
    idle(1);
    exp_dropped = (exp_dropped + n > 65535) ? 65535 : exp_dropped + n;
    n_cmp++; if (dropped_count_out !== 16'(exp_dropped)) begin n_bad++; $display("FAIL sat_dropped: got %h expected %h", dropped_count_out, exp_dropped); end
    n_cmp++; if (overflow_out !== 1'b0) begin n_bad++; $display("FAIL sat_overflow: got %b expected 0", overflow_out); end
  endtask
`endif

  initial begin
    @(negedge clk_in);
    test_reset();
    test_latency();
    test_out_of_range();
    test_random_draw();
    test_swap();
    test_reset_mid_op();
`ifndef FB_CLEAR_EN
    test_saturation();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
